// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the issue logic and muldiv_unit.
//   Start  - request strobe
//   Op     - operation select (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   Op_A   - rs operand from register file read port A
//   Op_B   - rt operand from register file read port B
//   Busy   - operation in progress
//   Done   - one-cycle pulse when HI/LO take a mult/div result
//   HI, LO - architectural HI/LO registers
// Modports: master drives the request, slave is the muldiv_unit side.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] Op_A;
  logic [WIDTH-1:0] Op_B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, Op_A, Op_B,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, Op_A, Op_B,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the MIPS HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU (WIDTH iterations + one sign-fixup cycle)
// and MTHI/MTLO (written on the start edge).
// Ports:
//   CLK - system clock, rising edge
//   RST - asynchronous active-high reset
//   bus - muldiv_if.slave: Start/Op/Op_A/Op_B in, Busy/Done/HI/LO out
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU use a combinational
// multiplier and finish on the start edge; divides stay iterative.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    CLK,
  input  logic    RST,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {partial product|remainder, multiplier|dividend}
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_orig_q, a_orig_d; // raw Op_A, needed for divide-by-zero HI
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;       // negate product / quotient
  logic               rneg_q, rneg_d;     // remainder takes sign of A
  logic               dz_q, dz_d;         // divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               sgn_op, fast_mul;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     msum, dtrial;
  logic [2*WIDTH-1:0] prod_fix, fast_prod;
  logic [WIDTH-1:0]   quo_fix, rem_raw, rem_fix;

  // Op[0]=0 selects the signed variant for the four arithmetic ops.
  assign sgn_op = !bus.Op[0];
  assign mag_a  = (sgn_op && bus.Op_A[WIDTH-1]) ? -bus.Op_A : bus.Op_A;
  assign mag_b  = (sgn_op && bus.Op_B[WIDTH-1]) ? -bus.Op_B : bus.Op_B;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b;
  // Low 2*WIDTH bits of the product of the extended operands are exact for
  // both signed and unsigned interpretations.
  assign ext_a     = {{WIDTH{sgn_op & bus.Op_A[WIDTH-1]}}, bus.Op_A};
  assign ext_b     = {{WIDTH{sgn_op & bus.Op_B[WIDTH-1]}}, bus.Op_B};
  assign fast_prod = ext_a * ext_b;
  assign fast_mul  = !bus.Op[1];
`else
  assign fast_prod = '0;
  assign fast_mul  = 1'b0;
`endif

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  assign msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Restoring divide step: trial-subtract divisor from the shifted remainder.
  assign dtrial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];
  assign rem_fix  = (rneg_q && (rem_raw != '0)) ? -rem_raw : rem_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_orig_d = a_orig_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (!bus.Op[2]) begin
            if (fast_mul) begin
              hi_d   = fast_prod[2*WIDTH-1:WIDTH];
              lo_d   = fast_prod[WIDTH-1:0];
              done_d = 1'b1;
            end else begin
              a_orig_d = bus.Op_A;
              is_div_d = bus.Op[1];
              dz_d     = bus.Op[1] && (bus.Op_B == '0);
              neg_d    = sgn_op && (bus.Op_A[WIDTH-1] ^ bus.Op_B[WIDTH-1]);
              rneg_d   = sgn_op && bus.Op_A[WIDTH-1];
              opnd_d   = mag_b;
              acc_d    = {{WIDTH{1'b0}}, mag_a};
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = CALC;
            end
          end else if (bus.Op[1:0] == 2'b00) begin
            hi_d = bus.Op_A;
          end else if (bus.Op[1:0] == 2'b01) begin
            lo_d = bus.Op_A;
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = dtrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                : {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = a_orig_q;
        end else if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_orig_q <= a_orig_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model of HI/LO and the operation timing.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.CLK(clk), .RST(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result of an arithmetic op, from plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = hi_m;
    lo = lo_m;
    case (op)
      3'b000: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'b001: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; end
      3'b010: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin
          q = sa / sb; r = sa % sb;
          p = q; lo = p[31:0];
          p = r; hi = p[31:0];
        end
      end
      3'b011: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                        input bit interfere);
    int cyc, bcnt;
    bit hold_bad, fast;
    logic [31:0] eh, el;
    model(op, a, b, eh, el);
`ifdef MULDIV_FAST_MUL_EN
    fast = !op[1];
`else
    fast = 1'b0;
`endif
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.Op_A = a; bus.Op_B = b;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Op_A = $urandom; bus.Op_B = $urandom;
    cyc = 0; bcnt = 0; hold_bad = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.Busy) begin
        bcnt++;
        if (bus.HI !== hi_m || bus.LO !== lo_m) hold_bad = 1'b1;
      end
      if (interfere && (cyc == 5 || cyc == 12)) begin
        bus.Start = 1'b1;
        bus.Op    = (cyc == 5) ? 3'b101 : 3'b011;
        bus.Op_A  = $urandom;
        bus.Op_B  = $urandom_range(1, 50);
      end else begin
        bus.Start = 1'b0;
      end
    end while (!bus.Done && cyc < 100);
    chk({tag, "_done"}, 64'(bus.Done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), fast ? 64'd1 : 64'd34);
    chk({tag, "_busycyc"}, 64'(bcnt), fast ? 64'd0 : 64'd33);
    chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
    chk({tag, "_HI"}, 64'(bus.HI), 64'(eh));
    chk({tag, "_LO"}, 64'(bus.LO), 64'(el));
    @(negedge clk);
    chk({tag, "_donepulse"}, 64'(bus.Done), 64'd0);
    chk({tag, "_busyafter"}, 64'(bus.Busy), 64'd0);
    hi_m = eh;
    lo_m = el;
  endtask

  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.Op_A = a; bus.Op_B = $urandom;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    if (op == 3'b100) hi_m = a;
    else if (op == 3'b101) lo_m = a;
    chk({tag, "_HI"}, 64'(bus.HI), 64'(hi_m));
    chk({tag, "_LO"}, 64'(bus.LO), 64'(lo_m));
    chk({tag, "_busy"}, 64'(bus.Busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done"}, 64'(bus.Done), 64'd0);
    chk({tag, "_busy2"}, 64'(bus.Busy), 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1;
    bus.Start = 1'b0; bus.Op = 3'b000; bus.Op_A = '0; bus.Op_B = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(negedge clk);
    chk("rst_HI", 64'(bus.HI), 64'd0);
    chk("rst_LO", 64'(bus.LO), 64'd0);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    rst = 1'b0;

    run_md("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max_HIconst", 64'(bus.HI), 64'h0000_0000_FFFF_FFFE);
    chk("multu_max_LOconst", 64'(bus.LO), 64'h0000_0000_0000_0001);
    run_md("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    chk("mult_neg_LOconst", 64'(bus.LO), 64'h0000_0000_FFFF_FFEB);
    run_md("div_neg", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    chk("div_neg_HIconst", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    chk("div_neg_LOconst", 64'(bus.LO), 64'h0000_0000_FFFF_FFFD);
    run_md("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_LOconst", 64'(bus.LO), 64'h0000_0000_8000_0000);
    run_md("div_zero_rem", 3'b010, 32'hFFFF_FFFA, 32'h0000_0003, 1'b0);
    run_md("divu_by0", 3'b011, 32'h0000_0064, 32'h0000_0000, 1'b0);
    chk("divu_by0_HIconst", 64'(bus.HI), 64'h0000_0000_0000_0064);
    run_md("div_by0_neg", 3'b010, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0);

    run_mt("mthi", 3'b100, 32'h1234_5678);
    run_md("multu_busy_ign", 3'b001, 32'd2, 32'd3, 1'b1);
    chk("busy_ign_HIconst", 64'(bus.HI), 64'd0);
    chk("busy_ign_LOconst", 64'(bus.LO), 64'd6);
    run_mt("reserved", 3'b110, 32'hDEAD_BEEF);
    run_mt("mtlo", 3'b101, 32'hCAFE_F00D);

    // Reset in the middle of a divide.
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 3'b011; bus.Op_A = 32'd100; bus.Op_B = 32'd7;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_HI", 64'(bus.HI), 64'd0);
    chk("midrst_LO", 64'(bus.LO), 64'd0);
    chk("midrst_busy", 64'(bus.Busy), 64'd0);
    chk("midrst_done", 64'(bus.Done), 64'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    rst = 1'b0;
    run_md("multu_after_rst", 3'b001, 32'd5, 32'd5, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        run_mt("rnd_mt", ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b101, $urandom);
      end else begin
        rop = 3'($urandom_range(0, 3));
        ra  = $urandom;
        rb  = $urandom;
        case ($urandom_range(0, 7))
          0: rb = '0;
          1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
          2: rb = 32'($urandom_range(1, 20));
          3: rb = -32'($urandom_range(1, 20));
          default: ;
        endcase
        run_md("rnd_md", rop, ra, rb, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
